// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU MEM stage
// and the host/debug port; one access at a time with a registered one-cycle ack.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              owner_host;
  logic              last_host;
  logic              grant;
  logic              grant_host;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // In RESP only the non-owner can be granted, which gives back-to-back alternation.
  always_comb begin
    grant      = 1'b0;
    grant_host = 1'b0;
    case (state)
      IDLE: begin
        grant      = cpu_req | host_req;
        grant_host = host_req & (~cpu_req | ~last_host);
      end
      RESP: begin
        grant      = owner_host ? cpu_req : host_req;
        grant_host = ~owner_host;
      end
      default: begin
        grant      = 1'b0;
        grant_host = 1'b0;
      end
    endcase
  end

  assign sel_we    = grant_host ? host_we    : cpu_we;
  assign sel_addr  = grant_host ? host_addr  : cpu_addr;
  assign sel_wdata = grant_host ? host_wdata : cpu_wdata;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner_host <= 1'b0;
      last_host  <= 1'b1;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      host_ack  <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant) begin
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_write  <= sel_we;
            mem_read   <= ~sel_we;
            owner_host <= grant_host;
            state      <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // mem_write still holds the access direction during this cycle.
          if (!mem_write) begin
            if (owner_host) host_rdata <= mem_rdata;
            else            cpu_rdata  <= mem_rdata;
          end
          if (owner_host) host_ack <= 1'b1;
          else            cpu_ack  <= 1'b1;
          last_host <= owner_host;
          state     <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the processor's MEM stage and a host/debug port. The host port replaces the direct `inaddress`/`outdata` peek path and can also write. It sits between the datapath and `data_mem`, issues one memory access at a time, and returns a registered response with a one-cycle acknowledge. Arbitration is round-robin, so neither requester starves.

## Interface
Parameters:
- ADDR_W, 10, word-address width (matches the 1024-entry data memory)
- DATA_W, 32, data width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack = 1, held until the next CPU read completes
- host_req, host_we, host_addr, host_wdata  in  as CPU port  host request signals
- host_ack, host_rdata  out  as CPU port  host response signals
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational read)
- busy  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the port that was not granted last. `last` resets to HOST, so CPU wins the first tie.
  - On grant: register the winner's addr/wdata/we into the mem_* outputs, set `owner`, go to ACCESS.
- ACCESS:
  - mem_write = we, mem_read = ~we; address and data are stable for the whole cycle.
  - Write: the memory commits the word on the closing edge.
  - Read: mem_rdata is captured into the owner's rdata register on the closing edge.
  - Go to RESP.
- RESP:
  - Owner's ack = 1 for exactly this cycle. mem_write = mem_read = 0. `last` ← owner.
  - The owner's req is ignored during RESP; the requester drops req in the cycle after ack.
  - If the other port's req is high: grant it directly and go to ACCESS (back-to-back service). Otherwise go to IDLE.
- Requester rules:
  - Addr/we/wdata must stay stable while req is high.
  - Deasserting req before ack is illegal. The arbiter completes the granted access regardless.
- The non-owner's rdata register is never modified.
- Write acks leave rdata unchanged.

## Timing
- Reset (reset = 0 at a clock edge):
  - State goes to IDLE; `last` = HOST.
  - cpu_ack = host_ack = 0, mem_write = mem_read = 0, busy = 0.
  - mem_addr = 0, mem_wdata = 0, cpu_rdata = host_rdata = 0.
- Latency: req sampled high in IDLE at edge N → ACCESS in cycle N+1 → ack in cycle N+2.
- Isolated access: 3 cycles from IDLE back to IDLE-ready.
- Sustained alternating traffic: one access per 2 cycles.
- A requester that re-asserts req in the cycle after its ack is granted in the next IDLE/RESP decision. It wins a tie against a port it was just served ahead of only under the round-robin rule.
- Reset mid-operation:
  - Reset edge closing ACCESS: the memory still sees mem_write = 1 and the write commits. No ack is issued and rdata is cleared.
  - Reset during RESP: the ack pulse is truncated to 0 from the reset edge on.
- mem_write and mem_read are never high together, and never high outside ACCESS.
- Simultaneous request arrival in IDLE with `last` = CPU: host is granted.

## Test plan
- Reset then idle: hold reset = 0 for 2 cycles, then release with no req → all outputs 0, busy = 0 for 10 cycles.
- CPU write then read: cpu write addr 0x064, data 0x0000002A → cpu_ack at N+2, mem_write high only in N+1. Then cpu read 0x064 → cpu_rdata = 0x2A with cpu_ack; host_rdata stays 0.
- Simultaneous requests from reset: both req at the same edge; CPU writes 0x11 to 0x005, host reads 0x005 → CPU acked first, host acked 2 cycles later with rdata = 0x11 (back-to-back, no IDLE cycle).
- Fairness: both ports hold req continuously (each re-requests right after ack) for 8 accesses → acks alternate CPU, HOST, CPU, …, with 4 each.
- Reset mid-write: host write 0xDEADBEEF to 0x3FF with reset = 0 at the edge closing ACCESS → no host_ack; a subsequent host read of 0x3FF returns 0xDEADBEEF.
- Address wrap/boundary: CPU read of 0x3FF and 0x000 → mem_addr = 0x3FF and 0x000 exactly, correct data returned, no aliasing.
